// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the UART boot loader: FSM states,
// error codes and header length.
package boot_loader_pkg;

    localparam int HDR_BYTES = 4;

    typedef enum logic [2:0] {
        READ_SIZE,
        READ_DATA,
        WRITE,
        READ_SUM,
        DONE,
        ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_OVERSIZE = 2'd1,
        ERR_CHECKSUM = 2'd2
    } err_t;

endpackage

// File: rtl/boot_loader_byte_packer.sv
// Assembles received bytes little-endian into one memory word; flush
// empties the word so unfilled upper lanes of a short last word read zero.
module byte_packer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [7:0]            data_byte,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  full
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [IDX_W-1:0] idx_reg;

    // full flags the push that completes the word, so the caller can leave
    // its byte-collection state in the same cycle.
    assign full = push && (idx_reg == IDX_W'(BYTES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_reg <= '0;
        end else if (flush) begin
            idx_reg <= '0;
        end else if (push) begin
            idx_reg <= full ? '0 : idx_reg + IDX_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    lane_reg <= '0;
                end else if (flush) begin
                    lane_reg <= '0;
                end else if (push && (idx_reg == IDX_W'(gi))) begin
                    lane_reg <= data_byte;
                end
            end
            assign word[8*gi +: 8] = lane_reg;
        end
    endgenerate

endmodule

// File: rtl/boot_loader.sv
// UART boot loader: reads a 4-byte little-endian size header, packs the
// payload into memory words, writes them from BASE_ADDR and checks a trailer sum.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int                  DATA_WIDTH  = 32,
    parameter int                  ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int                  MAX_BYTES   = 65536,
    parameter int                  CHECKSUM_EN = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  uart_out_valid,
    input  logic [7:0]            uart_out_data,
    input  logic                  uart_out_ready,
    output logic [ADDR_WIDTH-1:0] inst_mem_in_addr,
    output logic [DATA_WIDTH-1:0] inst_mem_in_data,
    output logic                  inst_mem_in_valid,
    input  logic                  inst_mem_in_ready,
    output logic                  completed,
    output logic                  error,
    output logic [1:0]            error_code
);
    localparam int BYTES = DATA_WIDTH / 8;

    state_t                state_reg, state_next;
    err_t                  err_reg, err_next;
    logic                  run_reg;
    logic [1:0]            hdr_cnt_reg, hdr_cnt_next;
    logic [31:0]           size_reg, size_next;
    logic [31:0]           cnt_reg, cnt_next;
    logic [7:0]            sum_reg, sum_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [31:0]           hdr_full;
    logic                  take;
    logic                  push;
    logic                  flush;
    logic                  word_full;
    state_t                after_payload;

    // run_reg keeps the byte request low while reset is held and raises it
    // on the first edge after release.
    assign uart_out_valid    = run_reg && ((state_reg == READ_SIZE) ||
                                           (state_reg == READ_DATA) ||
                                           (state_reg == READ_SUM));
    assign take              = uart_out_valid && uart_out_ready;
    assign inst_mem_in_valid = (state_reg == WRITE);
    assign inst_mem_in_addr  = addr_reg;
    assign completed         = (state_reg == DONE);
    assign error             = (state_reg == ERROR);
    assign error_code        = err_reg;
    assign hdr_full          = {uart_out_data, size_reg[23:0]};
    assign after_payload     = (CHECKSUM_EN != 0) ? READ_SUM : DONE;

    byte_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .data_byte (uart_out_data),
        .flush     (flush),
        .word      (inst_mem_in_data),
        .full      (word_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= READ_SIZE;
            err_reg     <= ERR_NONE;
            run_reg     <= 1'b0;
            hdr_cnt_reg <= '0;
            size_reg    <= '0;
            cnt_reg     <= '0;
            sum_reg     <= '0;
            addr_reg    <= BASE_ADDR;
        end else begin
            state_reg   <= state_next;
            err_reg     <= err_next;
            run_reg     <= 1'b1;
            hdr_cnt_reg <= hdr_cnt_next;
            size_reg    <= size_next;
            cnt_reg     <= cnt_next;
            sum_reg     <= sum_next;
            addr_reg    <= addr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        err_next     = err_reg;
        hdr_cnt_next = hdr_cnt_reg;
        size_next    = size_reg;
        cnt_next     = cnt_reg;
        sum_next     = sum_reg;
        addr_next    = addr_reg;
        push         = 1'b0;
        flush        = 1'b0;
        case (state_reg)
            READ_SIZE: begin
                if (take) begin
                    size_next[8*hdr_cnt_reg +: 8] = uart_out_data;
                    hdr_cnt_next = hdr_cnt_reg + 2'd1;
                    if (hdr_cnt_reg == 2'(HDR_BYTES - 1)) begin
                        if (hdr_full == 32'd0) begin
                            state_next = after_payload;
                        end else if (hdr_full > 32'(MAX_BYTES)) begin
                            state_next = ERROR;
                            err_next   = ERR_OVERSIZE;
                        end else begin
                            state_next = READ_DATA;
                        end
                    end
                end
            end
            READ_DATA: begin
                if (take) begin
                    push     = 1'b1;
                    sum_next = sum_reg + uart_out_data;
                    cnt_next = cnt_reg + 32'd1;
                    if (word_full || (cnt_next == size_reg)) begin
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                if (inst_mem_in_ready) begin
                    flush      = 1'b1;
                    addr_next  = addr_reg + ADDR_WIDTH'(BYTES);
                    state_next = (cnt_reg == size_reg) ? after_payload : READ_DATA;
                end
            end
            READ_SUM: begin
                if (take) begin
                    if (uart_out_data == sum_reg) begin
                        state_next = DONE;
                    end else begin
                        state_next = ERROR;
                        err_next   = ERR_CHECKSUM;
                    end
                end
            end
            DONE, ERROR: begin
                if (start) begin
                    state_next   = READ_SIZE;
                    err_next     = ERR_NONE;
                    hdr_cnt_next = '0;
                    size_next    = '0;
                    cnt_next     = '0;
                    sum_next     = '0;
                    addr_next    = BASE_ADDR;
                    flush        = 1'b1;
                end
            end
            default: state_next = READ_SIZE;
        endcase
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader (32-bit words, MAX_BYTES=16, checksum on):
// header/payload/trailer streams with hand-computed memory writes and status.
module tb_boot_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        uart_out_valid;
    logic [7:0]  uart_out_data = '0;
    logic        uart_out_ready = 1'b0;
    logic [31:0] inst_mem_in_addr;
    logic [31:0] inst_mem_in_data;
    logic        inst_mem_in_valid;
    logic        inst_mem_in_ready = 1'b1;
    logic        completed;
    logic        error;
    logic [1:0]  error_code;

    int checks = 0;
    int errors = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int base;

    boot_loader #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .BASE_ADDR   (32'h0),
        .MAX_BYTES   (16),
        .CHECKSUM_EN (1)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .uart_out_valid    (uart_out_valid),
        .uart_out_data     (uart_out_data),
        .uart_out_ready    (uart_out_ready),
        .inst_mem_in_addr  (inst_mem_in_addr),
        .inst_mem_in_data  (inst_mem_in_data),
        .inst_mem_in_valid (inst_mem_in_valid),
        .inst_mem_in_ready (inst_mem_in_ready),
        .completed         (completed),
        .error             (error),
        .error_code        (error_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (inst_mem_in_valid && inst_mem_in_ready) begin
            wr_addr_q.push_back(inst_mem_in_addr);
            wr_data_q.push_back(inst_mem_in_data);
            $display("write addr=%08h data=%08h", inst_mem_in_addr, inst_mem_in_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        uart_out_data  = b;
        uart_out_ready = 1'b1;
        while (!uart_out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!uart_out_valid) check("byte_request_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        uart_out_ready = 1'b0;
        $display("byte %02h sent", b);
    endtask

    task automatic send_header(input logic [31:0] size);
        for (int i = 0; i < 4; i++) send_byte(size[8*i +: 8]);
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!completed && !error && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!completed && !error) check(tag, 64'd0, 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_write(input string tag, input int idx,
                               input logic [31:0] addr, input logic [31:0] data);
        check({tag, "_addr"}, (idx < wr_addr_q.size()) ? wr_addr_q[idx] : 32'hxxxxxxxx, addr);
        check({tag, "_data"}, (idx < wr_data_q.size()) ? wr_data_q[idx] : 32'hxxxxxxxx, data);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_uart_valid", uart_out_valid, 1'b0);
        check("rst_mem_valid", inst_mem_in_valid, 1'b0);
        check("rst_addr", inst_mem_in_addr, 32'h0);
        check("rst_data", inst_mem_in_data, 32'h0);
        check("rst_completed", completed, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_code", error_code, 2'd0);
        reset = 1'b1;
        #1;
        check("rel_uart_valid_before_edge", uart_out_valid, 1'b0);
        @(posedge clk); #1;
        check("rel_uart_valid_after_edge", uart_out_valid, 1'b1);

        // 8 bytes 01..08, checksum 0x24
        base = wr_addr_q.size();
        send_header(32'd8);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        send_byte(8'h24);
        wait_end("t1_timeout");
        check("t1_nwrites", wr_addr_q.size() - base, 2);
        check_write("t1_w0", base, 32'h0, 32'h04030201);
        check_write("t1_w1", base + 1, 32'h4, 32'h08070605);
        check("t1_completed", completed, 1'b1);
        check("t1_error", error, 1'b0);
        check("t1_uart_valid", uart_out_valid, 1'b0);

        pulse_start();
        check("t2_restart_valid", uart_out_valid, 1'b1);
        check("t2_restart_completed", completed, 1'b0);

        // 5 bytes AA..EE, partial last word; sum = 0x3FC -> 0xFC
        base = wr_addr_q.size();
        send_header(32'd5);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        send_byte(8'hDD); send_byte(8'hEE);
        send_byte(8'hFC);
        wait_end("t2_timeout");
        check("t2_nwrites", wr_addr_q.size() - base, 2);
        check_write("t2_w0", base, 32'h0, 32'hDDCCBBAA);
        check_write("t2_w1", base + 1, 32'h4, 32'h000000EE);
        check("t2_completed", completed, 1'b1);

        // wrong checksum: writes still happen, then error code 2
        pulse_start();
        base = wr_addr_q.size();
        send_header(32'd8);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        send_byte(8'h00);
        wait_end("t3_timeout");
        check("t3_nwrites", wr_addr_q.size() - base, 2);
        check_write("t3_w1", base + 1, 32'h4, 32'h08070605);
        check("t3_error", error, 1'b1);
        check("t3_code", error_code, 2'd2);
        check("t3_completed", completed, 1'b0);
        pulse_start();
        check("t3_code_cleared", error_code, 2'd0);
        check("t3_error_cleared", error, 1'b0);
        check("t3_rearm_valid", uart_out_valid, 1'b1);

        // write stalled 5 cycles; trailer byte offered but must not be taken
        base = wr_addr_q.size();
        inst_mem_in_ready = 1'b0;
        send_header(32'd4);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        uart_out_data  = 8'hAA;
        uart_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_valid", inst_mem_in_valid, 1'b1);
            check("t4_stall_addr", inst_mem_in_addr, 32'h0);
            check("t4_stall_data", inst_mem_in_data, 32'h44332211);
            check("t4_stall_no_take", uart_out_valid, 1'b0);
            @(posedge clk); #1;
        end
        check("t4_stall_nwrites", wr_addr_q.size() - base, 0);
        inst_mem_in_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_valid_dropped", inst_mem_in_valid, 1'b0);
        check("t4_addr_advanced", inst_mem_in_addr, 32'h4);
        send_byte(8'hAA);
        wait_end("t4_timeout");
        check("t4_nwrites", wr_addr_q.size() - base, 1);
        check_write("t4_w0", base, 32'h0, 32'h44332211);
        check("t4_completed", completed, 1'b1);

        // oversize header 17 > 16
        pulse_start();
        base = wr_addr_q.size();
        send_header(32'd17);
        wait_end("t5_timeout");
        check("t5_error", error, 1'b1);
        check("t5_code", error_code, 2'd1);
        check("t5_uart_valid", uart_out_valid, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("t5_nwrites", wr_addr_q.size() - base, 0);

        // reset after 3 payload bytes, then a clean 4-byte load
        pulse_start();
        base = wr_addr_q.size();
        send_header(32'd8);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_uart_valid", uart_out_valid, 1'b0);
        check("t6_rst_mem_valid", inst_mem_in_valid, 1'b0);
        check("t6_rst_addr", inst_mem_in_addr, 32'h0);
        check("t6_rst_data", inst_mem_in_data, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_write", wr_addr_q.size() - base, 0);
        reset = 1'b1;
        send_header(32'd4);
        send_byte(8'h0D); send_byte(8'h0C); send_byte(8'h0B); send_byte(8'h0A);
        send_byte(8'h2E);
        wait_end("t6_timeout");
        check("t6_nwrites", wr_addr_q.size() - base, 1);
        check_write("t6_w0", base, 32'h0, 32'h0A0B0C0D);
        check("t6_completed", completed, 1'b1);
        check("t6_code", error_code, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
